// File: rtl/code_emit_pkg.sv
// Shared types for the opcode-stream writer: opcode bytes, emit kinds and
// the writer FSM states, plus the kind-to-literal-length mapping.
package code_emit_pkg;

   typedef enum logic [7:0] {
      _NOP   = 8'h00,
      _DOLIT = 8'h01,
      _DUP   = 8'h02,
      _DROP  = 8'h03,
      _ADD   = 8'h04,
      _EXIT  = 8'h05
   } opcode_e;

   typedef enum logic [1:0] {
      K_OP  = 2'd0,
      K_B8  = 2'd1,
      K_W16 = 2'd2,
      K_W32 = 2'd3
   } emit_kind_e;

   typedef enum logic {
      IDLE = 1'b0,
      WR   = 1'b1
   } emit_st_e;

   localparam int LEN_W = 3;

   // Number of literal bytes that trail the opcode byte.
   function automatic logic [LEN_W-1:0] kind_len(input emit_kind_e k);
      case (k)
         K_OP:    kind_len = 3'd0;
         K_B8:    kind_len = 3'd1;
         K_W16:   kind_len = 3'd2;
         K_W32:   kind_len = 3'd4;
         default: kind_len = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mb8_io.sv
// Byte-wide memory port: write enable, byte address and write data.
interface mb8_io #(
   parameter int ASZ = 17
);
   logic           we;
   logic [ASZ-1:0] ai;
   logic [7:0]     vi;

   modport master (output we, ai, vi);
   modport slave  (input  we, ai, vi);
endinterface

// File: rtl/spram8_128k.sv
// Single-port byte memory (2^ASZ bytes) written through an mb8_io slave port.
module spram8_128k #(
   parameter int ASZ = 17
) (
   input logic clk,
   mb8_io.slave mb
);

   logic [7:0] mem [0:(2**ASZ)-1];

   always_ff @(posedge clk) begin
      if (mb.we) mem[mb.ai] <= mb.vi;
   end

endmodule

// File: rtl/code_emit.sv
// Serialises emit requests (opcode plus little-endian literal) into byte
// memory at HERE, advancing HERE by one per byte written.
module code_emit
   import code_emit_pkg::*;
#(
   parameter int             DSZ = 32,
   parameter int             ASZ = 17,
   parameter logic [ASZ-1:0] IP0 = 'h100
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   mb8_io.master          mb_if,
   input  logic           req,
   input  emit_kind_e     kind,
   input  opcode_e        op,
   input  logic [DSZ-1:0] val,
   input  logic           set,
   input  logic [ASZ-1:0] here_i,
   output logic           rdy,
   output logic           done,
   output logic [ASZ-1:0] here
);

   emit_st_e         st_q, st_d;
   logic [ASZ-1:0]   here_q, here_d;
   logic [LEN_W-1:0] k_q, k_d;
   logic [LEN_W-1:0] len_q, len_d;
   opcode_e          op_q, op_d;
   logic [DSZ-1:0]   val_q, val_d;
   logic             done_q, done_d;
   logic [DSZ-1:0]   val_sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         here_q <= IP0;
         k_q    <= '0;
         len_q  <= '0;
         op_q   <= _NOP;
         val_q  <= '0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         here_q <= here_d;
         k_q    <= k_d;
         len_q  <= len_d;
         op_q   <= op_d;
         val_q  <= val_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      here_d = here_q;
      k_d    = k_q;
      len_d  = len_q;
      op_d   = op_q;
      val_d  = val_q;
      done_d = 1'b0;
      case (st_q)
         IDLE: begin
            // set wins over a coincident req, which is dropped unacknowledged
            if (en && set) begin
               here_d = here_i;
            end else if (en && req) begin
               op_d  = op;
               val_d = val;
               len_d = kind_len(kind);
               k_d   = '0;
               st_d  = WR;
            end
         end
         WR: begin
            if (en) begin
               here_d = here_q + 1'b1;
               k_d    = k_q + 3'd1;
               if (k_q == len_q) begin
                  st_d   = IDLE;
                  done_d = 1'b1;
               end
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // Byte k (k>=1) of the literal sits at bit 8*(k-1); k==0 selects the opcode.
   always_comb begin
      val_sh = val_q >> {k_q - 3'd1, 3'b000};
   end

   assign mb_if.we = (st_q == WR) && en;
   assign mb_if.ai = here_q;
   assign mb_if.vi = (k_q == '0) ? op_q : val_sh[7:0];

   assign rdy  = (st_q == IDLE);
   assign done = done_q;
   assign here = here_q;

endmodule
